lwc_do_sink: RTL and testbench
==============================

Name: lwc_do_sink

Overview:
- Downstream consumer of the LWC core's `do` output stream.
- Parses LWC-API output segment headers and strips them.
- Forwards payload words (ciphertext/plaintext/tag) on a byte-qualified stream with per-word keep and end-of-segment markers.
- Captures the final status word and flags protocol violations; sits between the LWC core and the host/DMA output path.

Parameters:
- LENW, 16, width of the header length field (bytes) and of the internal byte counter.
- TAGW, 128, expected-tag width in bits; used only when the optional feature is compiled in.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-low reset
- do_data  in  32  word from the LWC core
- do_valid  in  1  do_data valid
- do_last  in  1  core marks the final word of the message
- do_ready  out  1  sink accepts do_data this cycle
- m_data  out  32  payload word, byte 0 at [31:24]
- m_keep  out  4  valid-byte mask, MSB-first
- m_last  out  1  final payload word of the current segment
- m_type  out  4  segment type of the current word (header[31:28])
- m_valid  out  1  payload valid
- m_ready  in  1  downstream accepts payload
- status_valid  out  1  one-cycle pulse when the status word is consumed
- status_ok  out  1  1 = success (0xE), 0 = failure (0xF); held until next status
- err_proto  out  1  sticky protocol error; cleared only by reset

Behaviour:
- Interface: one clock `clk`; reset `rst` is synchronous and active-low.
- Reset (`rst`=0 at posedge) values:
  - do_ready=0, m_valid=0, m_data=0, m_keep=0, m_last=0, m_type=0.
  - status_valid=0, status_ok=0, err_proto=0.
  - FSM=HDR, byte counter=0.
  - Reset mid-segment discards all partial state; no payload word survives.
- Handshake: a transfer occurs on any posedge with valid&ready. do_ready is 0 in ERR. In DATA, do_ready = !m_valid | m_ready (single output register, full throughput, no combinational path m_ready→do_data).
- FSM:
  - HDR: accept one word.
    - type 0xE or 0xF → status_valid pulse next cycle, status_ok=(type==0xE), stay HDR.
    - Valid payload type (0x5,0x4,0x8 etc., anything except 0xE/0xF/0x0–0x3) → latch m_type. Then load cnt=header[LENW-1:0]; cnt==0 → stay HDR (empty segment, nothing emitted), else → DATA.
    - Type 0x0–0x3 → err_proto=1, go ERR.
  - DATA: each accepted word → m_valid=1 next cycle.
    - cnt>4 → m_keep=4'b1111, m_last=0, cnt-=4.
    - cnt<=4 → m_keep = leading cnt ones (1→1000, 2→1100, 3→1110, 4→1111), m_last=1, go HDR.
    - Padding bytes in the last word are forwarded unmasked; the sink uses m_keep.
  - ERR: terminal until reset; outputs frozen except any pending m_valid drains.
- Protocol checks:
  - do_last=1 on any word other than a status word → err_proto, ERR.
  - A status word with do_last=0 is accepted but also sets err_proto, FSM stays HDR.
- Latency: do word accepted at cycle N → m_valid/status_valid at N+1.
- Simultaneous: m_ready consumes the held word in the same cycle a new word loads (no bubble). status_valid never overlaps a payload word of the same transfer.

Optional Feature:
- Macro: LWC_DO_TAGCHK_EN.
- Defined:
  - Adds input `exp_tag` [TAGW-1:0] and output `tag_match` (1).
  - Words of type-0x8 segments are compared MSB-first against exp_tag.
  - tag_match=1 only if all TAGW/32 words match and the segment length equals TAGW/8; updated with status_valid.
  - status_ok = (type==0xE) & tag_match when a tag segment was seen since the previous status.
- Undefined: ports absent; status_ok depends on header type only.

Test Plan:
- Stream 0x52000009, 0x40499A1D, 0x1253C2FB, 0x83000000, m_ready=1 → three payload words; last has m_keep=1000, m_last=1, m_type=5.
- 0x83000010 then four words → four words with m_keep=1111, m_last on the 4th, m_type=8; zero-length header 0x83000000 → no m_valid.
- 0xE0000000 with do_last=1 → status_valid one cycle, status_ok=1, err_proto=0; 0xF0000000 → status_ok=0.
- m_ready toggling 1/0 every cycle during a 16-byte segment → no word lost or duplicated, order preserved, do_ready=0 whenever output is held.
- Header 0x30000004 → err_proto=1, do_ready stays 0; then rst=0 for one cycle → all outputs at reset values, next 0xE0000000 accepted.
- With LWC_DO_TAGCHK_EN, exp_tag=0x5D243400_332F001F_F23B1C0E_23118B11: matching tag then 0xE0000000 → status_ok=1; flip one bit → status_ok=0.

Source files
------------

// File: rtl/lwc_do_sink.sv
// LWC-API "do" stream sink: strips segment headers, forwards payload with keep/last, captures status.
// Optional expected-tag comparison is compiled in with `define LWC_DO_TAGCHK_EN.
module lwc_do_sink #(
    parameter int LENW = 16,
    parameter int TAGW = 128
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     do_data,
    input  logic            do_valid,
    input  logic            do_last,
    output logic            do_ready,
    output logic [31:0]     m_data,
    output logic [3:0]      m_keep,
    output logic            m_last,
    output logic [3:0]      m_type,
    output logic            m_valid,
    input  logic            m_ready,
    output logic            status_valid,
    output logic            status_ok,
    output logic            err_proto
`ifdef LWC_DO_TAGCHK_EN
    ,
    input  logic [TAGW-1:0] exp_tag,
    output logic            tag_match
`endif
);

    typedef enum logic [1:0] {S_HDR, S_DATA, S_ERR} state_t;

    state_t          state, state_nxt;
    logic [LENW-1:0] cnt, cnt_nxt;
    logic [3:0]      seg_type;
    logic [3:0]      hdr_type;
    logic            seg_load, word_load, stat_pulse, proto_err;
    logic [3:0]      keep_nxt;
    logic            last_nxt;

    assign hdr_type = do_data[31:28];

    always_ff @(posedge clk) begin
        if (!rst) state <= S_HDR;
        else      state <= state_nxt;
    end

    // Headers never occupy the output register, so HDR accepts even while a payload word is held.
    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        do_ready   = 1'b0;
        seg_load   = 1'b0;
        word_load  = 1'b0;
        stat_pulse = 1'b0;
        proto_err  = 1'b0;
        keep_nxt   = 4'b1111;
        last_nxt   = 1'b0;
        case (state)
            S_HDR: begin
                do_ready = rst;
                if (do_valid && do_ready) begin
                    if (hdr_type >= 4'hE) begin
                        stat_pulse = 1'b1;
                        proto_err  = !do_last;
                    end else if (hdr_type <= 4'h3 || do_last) begin
                        proto_err = 1'b1;
                        state_nxt = S_ERR;
                    end else begin
                        seg_load = 1'b1;
                        cnt_nxt  = do_data[LENW-1:0];
                        if (do_data[LENW-1:0] != '0) state_nxt = S_DATA;
                    end
                end
            end
            S_DATA: begin
                do_ready = rst && (!m_valid || m_ready);
                if (do_valid && do_ready) begin
                    if (do_last) begin
                        proto_err = 1'b1;
                        state_nxt = S_ERR;
                    end else begin
                        word_load = 1'b1;
                        if (cnt > LENW'(4)) begin
                            cnt_nxt = cnt - LENW'(4);
                        end else begin
                            cnt_nxt   = '0;
                            last_nxt  = 1'b1;
                            state_nxt = S_HDR;
                            case (cnt[2:0])
                                3'd1:    keep_nxt = 4'b1000;
                                3'd2:    keep_nxt = 4'b1100;
                                3'd3:    keep_nxt = 4'b1110;
                                default: keep_nxt = 4'b1111;
                            endcase
                        end
                    end
                end
            end
            default: ;
        endcase
    end

`ifdef LWC_DO_TAGCHK_EN
    logic [TAGW-1:0] tag_sr;
    logic            tag_seen, tag_ok;

    // Tag words are checked MSB-first by shifting a copy of exp_tag as words arrive.
    always_ff @(posedge clk) begin
        if (!rst) begin
            tag_sr    <= '0;
            tag_seen  <= 1'b0;
            tag_ok    <= 1'b0;
            tag_match <= 1'b0;
        end else begin
            if (seg_load && hdr_type == 4'h8) begin
                tag_seen <= 1'b1;
                tag_ok   <= (do_data[LENW-1:0] == LENW'(TAGW/8));
                tag_sr   <= exp_tag;
            end else if (word_load && seg_type == 4'h8) begin
                tag_ok <= tag_ok && (do_data == tag_sr[TAGW-1 -: 32]);
                tag_sr <= tag_sr << 32;
            end
            if (stat_pulse) begin
                tag_match <= tag_seen && tag_ok;
                tag_seen  <= 1'b0;
            end
        end
    end

    logic stat_ok_nxt;
    assign stat_ok_nxt = (hdr_type == 4'hE) && (!tag_seen || tag_ok);
`else
    logic stat_ok_nxt;
    assign stat_ok_nxt = (hdr_type == 4'hE);
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt          <= '0;
            seg_type     <= 4'h0;
            m_data       <= 32'h0;
            m_keep       <= 4'h0;
            m_last       <= 1'b0;
            m_type       <= 4'h0;
            m_valid      <= 1'b0;
            status_valid <= 1'b0;
            status_ok    <= 1'b0;
            err_proto    <= 1'b0;
        end else begin
            cnt          <= cnt_nxt;
            status_valid <= stat_pulse;
            if (stat_pulse) status_ok <= stat_ok_nxt;
            if (proto_err)  err_proto <= 1'b1;
            if (seg_load)   seg_type  <= hdr_type;
            if (word_load) begin
                m_valid <= 1'b1;
                m_data  <= do_data;
                m_keep  <= keep_nxt;
                m_last  <= last_nxt;
                m_type  <= seg_type;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_lwc_do_sink.sv
// Directed self-checking bench for lwc_do_sink; tag checks are built in only with LWC_DO_TAGCHK_EN.
module tb_lwc_do_sink;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] do_data;
    logic        do_valid, do_last, do_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep, m_type;
    logic        m_last, m_valid, m_ready;
    logic        status_valid, status_ok, err_proto;
`ifdef LWC_DO_TAGCHK_EN
    logic [127:0] exp_tag;
    logic         tag_match;
`endif

    int testCount = 0;
    int failCount = 0;
    int statCount = 0;
    logic toggleMode = 1'b0;
    logic readyLevel = 1'b0;
    logic holdChk = 1'b0;
    logic [40:0] gotQ[$];
    logic [40:0] expQ[$];

    lwc_do_sink dut (
        .clk(clk), .rst(rst),
        .do_data(do_data), .do_valid(do_valid), .do_last(do_last), .do_ready(do_ready),
        .m_data(m_data), .m_keep(m_keep), .m_last(m_last), .m_type(m_type),
        .m_valid(m_valid), .m_ready(m_ready),
        .status_valid(status_valid), .status_ok(status_ok), .err_proto(err_proto)
`ifdef LWC_DO_TAGCHK_EN
        , .exp_tag(exp_tag), .tag_match(tag_match)
`endif
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        testCount++;
        if (got !== exp) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(posedge clk) begin
        #1;
        m_ready = toggleMode ? ~m_ready : readyLevel;
    end

    // Outputs are sampled on the falling edge, where they are stable for the next transfer.
    always @(negedge clk) begin
        if (m_valid && m_ready) gotQ.push_back({m_data, m_keep, m_last, m_type});
        if (status_valid) statCount++;
        if (holdChk && do_valid && m_valid && !m_ready) checkOutput("holdReady", 64'(do_ready), 64'd0);
    end

    task automatic applyStimulus(input logic [31:0] d, input logic l);
        int n = 0;
        do_data  = d;
        do_last  = l;
        do_valid = 1'b1;
        @(negedge clk);
        while (!do_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!do_ready) checkOutput("readyTimeout", 64'(do_ready), 64'd1);
        @(posedge clk);
        #1;
        do_valid = 1'b0;
        do_last  = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expectWord(input logic [31:0] d, input logic [3:0] k, input logic l, input logic [3:0] t);
        expQ.push_back({d, k, l, t});
    endtask

    task automatic checkQueue(input string tag);
        checkOutput({tag, "_count"}, 64'(gotQ.size()), 64'(expQ.size()));
        for (int i = 0; i < gotQ.size() && i < expQ.size(); i++)
            checkOutput({tag, "_word"}, 64'(gotQ[i]), 64'(expQ[i]));
        gotQ.delete();
        expQ.delete();
    endtask

    task automatic checkResetValues(input string tag);
        @(negedge clk);
        checkOutput({tag, "_do_ready"}, 64'(do_ready), 64'd0);
        checkOutput({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        checkOutput({tag, "_m_data"}, 64'(m_data), 64'd0);
        checkOutput({tag, "_m_keep"}, 64'(m_keep), 64'd0);
        checkOutput({tag, "_m_last"}, 64'(m_last), 64'd0);
        checkOutput({tag, "_m_type"}, 64'(m_type), 64'd0);
        checkOutput({tag, "_status_valid"}, 64'(status_valid), 64'd0);
        checkOutput({tag, "_status_ok"}, 64'(status_ok), 64'd0);
        checkOutput({tag, "_err_proto"}, 64'(err_proto), 64'd0);
    endtask

    task automatic resetPulse(input string tag);
        rst = 1'b0;
        @(posedge clk);
        checkResetValues(tag);
        @(posedge clk);
        #1;
        rst = 1'b1;
        statCount = 0;
        gotQ.delete();
        expQ.delete();
    endtask

    initial begin
        logic readySeen;
        rst      = 1'b0;
        do_data  = 32'h0;
        do_valid = 1'b0;
        do_last  = 1'b0;
        m_ready  = 1'b0;
`ifdef LWC_DO_TAGCHK_EN
        exp_tag  = 128'h5D243400_332F001F_F23B1C0E_23118B11;
`endif
        repeat (2) @(posedge clk);
        checkResetValues("reset");
        @(posedge clk);
        #1;
        rst = 1'b1;
        readyLevel = 1'b1;
        waitCycles(1);

        // 9-byte segment: two full words then a single-byte tail
        applyStimulus(32'h52000009, 1'b0);
        applyStimulus(32'h40499A1D, 1'b0);
        applyStimulus(32'h1253C2FB, 1'b0);
        applyStimulus(32'h83000000, 1'b0);
        expectWord(32'h40499A1D, 4'b1111, 1'b0, 4'h5);
        expectWord(32'h1253C2FB, 4'b1111, 1'b0, 4'h5);
        expectWord(32'h83000000, 4'b1000, 1'b1, 4'h5);
        waitCycles(3);
        checkQueue("seg9");

        applyStimulus(32'h83000010, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(32'hA0A0A0A0 + 32'(i), 1'b0);
        applyStimulus(32'h83000000, 1'b0);
        for (int i = 0; i < 4; i++) expectWord(32'hA0A0A0A0 + 32'(i), 4'b1111, i == 3, 4'h8);
        waitCycles(3);
        checkQueue("seg16_empty");

        applyStimulus(32'h4700000F, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(32'hC0000000 + 32'(i), 1'b0);
        for (int i = 0; i < 4; i++) expectWord(32'hC0000000 + 32'(i), (i == 3) ? 4'b1110 : 4'b1111, i == 3, 4'h4);
        waitCycles(3);
        checkQueue("seg15");

        applyStimulus(32'hE0000000, 1'b1);
        waitCycles(3);
        checkOutput("statPassCount", 64'(statCount), 64'd1);
        checkOutput("statPassOk", 64'(status_ok), 64'd1);
        checkOutput("statPassErr", 64'(err_proto), 64'd0);
        applyStimulus(32'hF0000000, 1'b1);
        waitCycles(3);
        checkOutput("statFailCount", 64'(statCount), 64'd2);
        checkOutput("statFailOk", 64'(status_ok), 64'd0);

        // Status without do_last flags an error but the parser keeps going
        applyStimulus(32'hE0000000, 1'b0);
        applyStimulus(32'h44000002, 1'b0);
        applyStimulus(32'hBEEF1234, 1'b0);
        expectWord(32'hBEEF1234, 4'b1100, 1'b1, 4'h4);
        waitCycles(3);
        checkOutput("statNoLastErr", 64'(err_proto), 64'd1);
        checkOutput("statNoLastOk", 64'(status_ok), 64'd1);
        checkQueue("afterStatNoLast");

        resetPulse("rst1");
        toggleMode = 1'b1;
        applyStimulus(32'h55000010, 1'b0);
        holdChk = 1'b1;
        for (int i = 0; i < 4; i++) applyStimulus(32'hD1D2D300 + 32'(i), 1'b0);
        holdChk = 1'b0;
        for (int i = 0; i < 4; i++) expectWord(32'hD1D2D300 + 32'(i), 4'b1111, i == 3, 4'h5);
        waitCycles(4);
        toggleMode = 1'b0;
        waitCycles(2);
        checkQueue("toggle");
        checkOutput("toggleErr", 64'(err_proto), 64'd0);

        // Reset while a payload word is held must drop it
        readyLevel = 1'b0;
        waitCycles(1);
        applyStimulus(32'h55000008, 1'b0);
        applyStimulus(32'h11111111, 1'b0);
        waitCycles(1);
        checkOutput("heldValid", 64'(m_valid), 64'd1);
        resetPulse("rstMid");
        readyLevel = 1'b1;
        applyStimulus(32'hE0000000, 1'b1);
        waitCycles(3);
        checkQueue("rstMidDropped");
        checkOutput("rstMidStat", 64'(statCount), 64'd1);
        checkOutput("rstMidErr", 64'(err_proto), 64'd0);

        applyStimulus(32'h52000004, 1'b1);
        waitCycles(1);
        checkOutput("lastOnHdrErr", 64'(err_proto), 64'd1);
        resetPulse("rst2");

        applyStimulus(32'h30000004, 1'b0);
        do_data  = 32'h12345678;
        do_valid = 1'b1;
        readySeen = 1'b0;
        repeat (4) begin
            @(negedge clk);
            readySeen = readySeen | do_ready;
        end
        @(posedge clk);
        #1;
        do_valid = 1'b0;
        checkOutput("badTypeErr", 64'(err_proto), 64'd1);
        checkOutput("errReady", 64'(readySeen), 64'd0);
        resetPulse("rst3");
        applyStimulus(32'hE0000000, 1'b1);
        waitCycles(3);
        checkOutput("afterErrStat", 64'(statCount), 64'd1);
        checkOutput("afterErrOk", 64'(status_ok), 64'd1);
        checkOutput("afterErrErr", 64'(err_proto), 64'd0);
        checkQueue("afterErr");

`ifdef LWC_DO_TAGCHK_EN
        applyStimulus(32'h80000010, 1'b0);
        applyStimulus(32'h5D243400, 1'b0);
        applyStimulus(32'h332F001F, 1'b0);
        applyStimulus(32'hF23B1C0E, 1'b0);
        applyStimulus(32'h23118B11, 1'b0);
        applyStimulus(32'hE0000000, 1'b1);
        waitCycles(3);
        checkOutput("tagGoodOk", 64'(status_ok), 64'd1);
        checkOutput("tagGoodMatch", 64'(tag_match), 64'd1);
        applyStimulus(32'h80000010, 1'b0);
        applyStimulus(32'h5D243400, 1'b0);
        applyStimulus(32'h332F001F, 1'b0);
        applyStimulus(32'hF23B1C0E, 1'b0);
        applyStimulus(32'h23118B10, 1'b0);
        applyStimulus(32'hE0000000, 1'b1);
        waitCycles(3);
        checkOutput("tagBadOk", 64'(status_ok), 64'd0);
        checkOutput("tagBadMatch", 64'(tag_match), 64'd0);
        gotQ.delete();
`endif

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end

endmodule
